sp_responder: RTL

//  Scratchpad-side responder for the vector load/store request interface. Accepts one

---
 rtl/vector_pkg.sv | 24 ++
 rtl/sp_bank.sv | 43 ++++
 rtl/sp_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/vector_pkg.sv
// ---------------------------------------------------------------------------
// vector_pkg
//   Shared definitions for the vector load/store request path: the LOAD/STORE
//   op encodings driven on sp_op and the scratchpad responder state type.
//   Has no ports. Imported by sp_responder.
// ---------------------------------------------------------------------------
package vector_pkg;

    // Op encodings on the 7-bit sp_op bus. Any other value is a NOP.
    localparam logic [6:0] LOAD  = 7'b000_0011;
    localparam logic [6:0] STORE = 7'b010_0011;

    typedef enum logic [1:0] {
        IDLE,
        ACC_1,
        ACC_2,
        RESP
    } sp_state_t;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == LOAD) || (op == STORE);
    endfunction

endpackage

// File: rtl/sp_bank.sv
// ---------------------------------------------------------------------------
// sp_bank
//   Single-ported synchronous scratchpad RAM bank. When en is high, one access
//   happens per cycle: a write when we=1, otherwise a read. rdata is
//   registered, so read data appears one cycle after the access and holds
//   until the next access.
// Ports
//   CLK    in   1    clock
//   en     in   1    access enable
//   we     in   1    write enable (qualified by en)
//   addr   in   AW   word index
//   wdata  in   DW   write data
//   rdata  out  DW   registered read data
// ---------------------------------------------------------------------------
module sp_bank #(
    parameter  int DEPTH = 256,
    parameter  int DW    = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    // NOTE: the array has no reset. SRAM contents cannot be cleared in one
    // cycle, and a reset here would force the array into discrete flops.
    logic [DW-1:0] mem [DEPTH];

    // NOTE: clocked state always uses non-blocking assignments, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sp_responder.sv
// ---------------------------------------------------------------------------
// sp_responder
//   Scratchpad-side responder for the vector load/store unit. Accepts one
//   dual-lane LOAD/STORE command while idle and serves it on two single-ported
//   banks. The lane id selects the bank. When both lanes target the same bank,
//   lane A is served first and lane B second. Completion is signalled by a
//   one-cycle dhit pulse.
// Optional feature: define SP_RESPONDER_OOB_CHECK_EN to flag addresses
//   >= DEPTH. In that case OOB stores are dropped, OOB loads return 0, and
//   sp_err is raised with dhit. Without it, addresses wrap modulo DEPTH and
//   sp_err is tied 0.
// Ports
//   CLK                  in   1    clock
//   RST                  in   1    synchronous active-high reset
//   sp_op                in   7    LOAD / STORE start a request, else NOP
//   sp_addr_a/_b         in   16   lane word address
//   sp_store_data_a/_b   in   DW   lane store data
//   sp_id_a/_b           in   1    lane bank select
//   dhit                 out  1    completion pulse
//   load_data_a/_b       out  DW   load results, valid with dhit, then held
//   busy                 out  1    request in flight (through the dhit cycle)
//   sp_err               out  1    out-of-range flag, valid with dhit
// ---------------------------------------------------------------------------
module sp_responder
    import vector_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int DW    = 16,
    parameter int LAT   = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [6:0]    sp_op,
    input  logic [15:0]   sp_addr_a,
    input  logic [15:0]   sp_addr_b,
    input  logic [DW-1:0] sp_store_data_a,
    input  logic [DW-1:0] sp_store_data_b,
    input  logic          sp_id_a,
    input  logic          sp_id_b,
    output logic          dhit,
    output logic [DW-1:0] load_data_a,
    output logic [DW-1:0] load_data_b,
    output logic          busy,
    output logic          sp_err
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = $clog2(LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

    sp_state_t     state, state_n;
    logic [CW-1:0] cnt;
    logic          last_cyc, accept, serve_a, serve_b;

    // Captured request. This is payload only and is always rewritten on
    // accept, so it carries no reset.
    logic          is_store_q, conflict_q, id_a_q, id_b_q;
    logic [15:0]   addr_a_q, addr_b_q;
    logic [DW-1:0] wdata_a_q, wdata_b_q;
    logic [DW-1:0] stage_a_q;

    logic [DW-1:0] ld_a_q, ld_b_q;
    logic          oob_a, oob_b;

    logic [1:0]    bank_en, bank_we;
    logic [AW-1:0] bank_addr  [2];
    logic [DW-1:0] bank_wdata [2];
    logic [DW-1:0] bank_rdata [2];

`ifdef SP_RESPONDER_OOB_CHECK_EN
    assign oob_a  = {16'd0, addr_a_q} >= 32'(DEPTH);
    assign oob_b  = {16'd0, addr_b_q} >= 32'(DEPTH);
    assign sp_err = (state == RESP) && (oob_a || oob_b);
`else
    // Upper address bits are deliberately dropped; the address wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{addr_a_q[15:AW], addr_b_q[15:AW]};
    assign oob_a  = 1'b0;
    assign oob_b  = 1'b0;
    assign sp_err = 1'b0;
`endif

    assign last_cyc = (cnt == CNT_LAST);
    assign dhit     = (state == RESP);
    assign busy     = (state != IDLE);

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem_op(sp_op)) begin
                    accept  = 1'b1;
                    state_n = ACC_1;
                end
            end
            ACC_1:   if (last_cyc) state_n = conflict_q ? ACC_2 : RESP;
            ACC_2:   if (last_cyc) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            ld_a_q <= '0;
            ld_b_q <= '0;
        end else begin
            state <= state_n;
            // The phase counter restarts on every phase entry.
            if (state_n != state) begin
                cnt <= '0;
            end else if (state == ACC_1 || state == ACC_2) begin
                cnt <= cnt + CW'(1);
            end
            // Hold whatever was presented with dhit until the next dhit.
            if (state == RESP) begin
                ld_a_q <= load_data_a;
                ld_b_q <= load_data_b;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            is_store_q <= (sp_op == STORE);
            conflict_q <= (sp_id_a == sp_id_b);
            id_a_q     <= sp_id_a;
            id_b_q     <= sp_id_b;
            addr_a_q   <= sp_addr_a;
            addr_b_q   <= sp_addr_b;
            wdata_a_q  <= sp_store_data_a;
            wdata_b_q  <= sp_store_data_b;
        end
        // On a conflict, lane A's read result sits in the shared bank's rdata
        // only until lane B's access. Park it here during ACC_2.
        if (state == ACC_2 && cnt == '0) begin
            stage_a_q <= bank_rdata[id_a_q];
        end
    end

    // Lane-to-bank steering. A lane touches its bank only in the last cycle
    // of its phase. RST blocks a write that would otherwise commit on the
    // reset edge.
    always_comb begin
        serve_a = (state == ACC_1) && last_cyc && !RST;
        serve_b = ((state == ACC_1 && !conflict_q) || state == ACC_2) && last_cyc && !RST;
        for (int k = 0; k < 2; k++) begin
            bank_en[k]    = 1'b0;
            bank_we[k]    = 1'b0;
            bank_addr[k]  = addr_a_q[AW-1:0];
            bank_wdata[k] = wdata_a_q;
            if (serve_a && id_a_q == 1'(k)) begin
                bank_en[k]    = 1'b1;
                bank_we[k]    = is_store_q && !oob_a;
                bank_addr[k]  = addr_a_q[AW-1:0];
                bank_wdata[k] = wdata_a_q;
            end
            if (serve_b && id_b_q == 1'(k)) begin
                bank_en[k]    = 1'b1;
                bank_we[k]    = is_store_q && !oob_b;
                bank_addr[k]  = addr_b_q[AW-1:0];
                bank_wdata[k] = wdata_b_q;
            end
        end
    end

    // Fresh load results are shown during RESP. At all other times the held
    // values are shown.
    always_comb begin
        load_data_a = ld_a_q;
        load_data_b = ld_b_q;
        if (state == RESP && !is_store_q) begin
            load_data_a = oob_a ? '0 : (conflict_q ? stage_a_q : bank_rdata[id_a_q]);
            load_data_b = oob_b ? '0 : bank_rdata[id_b_q];
        end
    end

    sp_bank #(.DEPTH(DEPTH), .DW(DW)) u_bank0 (
        .CLK   (CLK),
        .en    (bank_en[0]),
        .we    (bank_we[0]),
        .addr  (bank_addr[0]),
        .wdata (bank_wdata[0]),
        .rdata (bank_rdata[0])
    );

    sp_bank #(.DEPTH(DEPTH), .DW(DW)) u_bank1 (
        .CLK   (CLK),
        .en    (bank_en[1]),
        .we    (bank_we[1]),
        .addr  (bank_addr[1]),
        .wdata (bank_wdata[1]),
        .rdata (bank_rdata[1])
    );

endmodule
